// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared constants and FSM state encoding for the fetch stage
package ifu_fetch_pkg;

    localparam int         IFU_TO_IDU_BUS   = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_RESP     = 2'd1,
        S_HOLD     = 2'd2,
        S_WAIT_NPC = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - non-speculative instruction fetch with inline AXI4-Lite read master
// Optional IFU_ACCESS_FAULT_EN: sticky fetch_fault on error response or misaligned next PC.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic [DATA_WIDTH-1:0]     ifu_araddr,
    output logic                      ifu_arvalid,
    input  logic                      ifu_arready,
    input  logic [DATA_WIDTH-1:0]     ifu_rdata,
    input  logic [1:0]                ifu_rresp,
    input  logic                      ifu_rvalid,
    output logic                      ifu_rready,
    output logic [IFU_TO_IDU_BUS-1:0] ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,
    input  logic [DATA_WIDTH-1:0]     nextpc,
    input  logic                      nextpc_valid,
    output logic                      fetch_fault
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;

`ifdef IFU_ACCESS_FAULT_EN
    logic fault_q, fault_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
`ifdef IFU_ACCESS_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
`ifdef IFU_ACCESS_FAULT_EN
            fault_q <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inst_d           = inst_q;
`ifdef IFU_ACCESS_FAULT_EN
        fault_d          = fault_q;
`endif
        ifu_arvalid      = 1'b0;
        ifu_rready       = 1'b0;
        ifu_to_idu_valid = 1'b0;
        case (state_q)
            S_REQ: begin
                ifu_arvalid = 1'b1;
                if (ifu_arready) state_d = S_RESP;
            end
            S_RESP: begin
                ifu_rready = 1'b1;
                if (ifu_rvalid) begin
`ifdef IFU_ACCESS_FAULT_EN
                    if (ifu_rresp != AXI_RESP_OKAY) begin
                        fault_d = 1'b1;
                        state_d = S_WAIT_NPC;
                    end else begin
                        inst_d  = ifu_rdata;
                        state_d = S_HOLD;
                    end
`else
                    inst_d  = ifu_rdata;
                    state_d = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
                ifu_to_idu_valid = 1'b1;
                if (idu_allowin) state_d = S_WAIT_NPC;
            end
            S_WAIT_NPC: begin
                if (nextpc_valid) begin
`ifdef IFU_ACCESS_FAULT_EN
                    // A faulted stage never leaves WAIT_NPC; only reset recovers it.
                    if (fault_q || nextpc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = nextpc;
                        state_d = S_REQ;
                    end
`else
                    pc_d    = nextpc;
                    state_d = S_REQ;
`endif
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign ifu_araddr     = pc_q;
    assign ifu_to_idu_bus = {pc_q, inst_q};

`ifdef IFU_ACCESS_FAULT_EN
    assign fetch_fault = fault_q;

    a_no_fault: assert property (@(posedge clock) disable iff (reset) !fault_q)
        else $fatal(1, "ifu fetch fault at pc=%h", pc_q);
`else
    logic unused_rresp;
    assign unused_rresp = (ifu_rresp != AXI_RESP_OKAY);
    assign fetch_fault  = 1'b0;
`endif

    // A next-PC pulse outside WAIT_NPC (including the HOLD handshake cycle) is a pipeline bug.
    a_npc_protocol: assert property (@(posedge clock) disable iff (reset)
        nextpc_valid |-> state_q == S_WAIT_NPC);

endmodule
